// File: rtl/sar_afe_if.sv
// Signal bundle between sar_logic (master) and the SAR front-end model (slave).
// The master drives the conversion controls and the stand-in analog code; the slave reports back.
interface sar_afe_if #(
    parameter int N = 8
);
    logic [N-1:0] vin;
    logic         sample_clk;
    logic [N-1:0] D;
    logic         reg_clk;
    logic         EOC;
    logic         comparator_out;
    logic [N-1:0] vhold;
    logic [N-1:0] result;
    logic         result_valid;
    logic         conv_err;
    logic [15:0]  conv_count;

    modport master (
        output vin, sample_clk, D, reg_clk, EOC,
        input  comparator_out, vhold, result, result_valid, conv_err, conv_count
    );

    modport slave (
        input  vin, sample_clk, D, reg_clk, EOC,
        output comparator_out, vhold, result, result_valid, conv_err, conv_count
    );
endinterface

// File: rtl/sar_afe_model.sv
// Cycle-based SAR front end: track/hold, offset CDAC comparator with configurable latency,
// and a checker that compares each finished conversion against the held sample.
module sar_afe_model #(
    parameter int N       = 8,
    parameter int CMP_LAT = 1,
    parameter int OFFSET  = 0,
    parameter int TOL     = 0
) (
    input  logic     clk,
    input  logic     rst,
    sar_afe_if.slave bus
);
    localparam int BW = $clog2(N + 1) + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] TRACK   = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic signed [N+1:0] OFF_S = (N + 2)'(OFFSET);
    localparam logic signed [N+1:0] TOL_S = (N + 2)'(TOL);
    localparam logic signed [N+1:0] MAX_S = (N + 2)'((1 << N) - 1);

    logic [1:0]         state_q, state_d;
    logic               sc_q, rc_q, eoc_q;
    logic [N-1:0]       vhold_q, vhold_d;
    logic [N-1:0]       result_q, result_d;
    logic               rv_q, rv_d;
    logic               err_q, err_d;
    logic [15:0]        count_q, count_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CMP_LAT-1:0] cmp_q;

    logic               sc_rise, sc_fall, rc_rise, eoc_rise;
    logic               raw, err_hit;
    logic signed [N+1:0] dac, hold_s, exp_s, exp_c, diff, absd;

    assign sc_rise  = bus.sample_clk & ~sc_q;
    assign sc_fall  = ~bus.sample_clk & sc_q;
    assign rc_rise  = bus.reg_clk & ~rc_q;
    assign eoc_rise = bus.EOC & ~eoc_q;

    always_comb begin
        dac    = $signed({2'b00, bus.D}) + OFF_S;
        hold_s = $signed({2'b00, vhold_q});
        raw    = (state_q == CONVERT) && (dac <= hold_s);

        // Ideal code for the held sample once the comparator offset is removed, clamped to range.
        exp_s = hold_s - OFF_S;
        if (exp_s < 0) begin
            exp_c = '0;
        end else if (exp_s > MAX_S) begin
            exp_c = MAX_S;
        end else begin
            exp_c = exp_s;
        end
        diff    = $signed({2'b00, bus.D}) - exp_c;
        absd    = (diff < 0) ? -diff : diff;
        err_hit = (absd > TOL_S) || (bit_cnt_q != BW'(N));
    end

    always_comb begin
        state_d   = state_q;
        vhold_d   = vhold_q;
        result_d  = result_q;
        rv_d      = 1'b0;
        err_d     = err_q;
        count_d   = count_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.sample_clk) state_d = TRACK;
            end
            TRACK: begin
                vhold_d = bus.vin;
                if (sc_fall) begin
                    state_d   = CONVERT;
                    bit_cnt_d = '0;
                end
            end
            CONVERT: begin
                if (rc_rise && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + 1'b1;
                // EOC takes priority; a simultaneous sample_clk rise only redirects to TRACK.
                if (eoc_rise) begin
                    result_d = bus.D;
                    rv_d     = 1'b1;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    if (err_hit) err_d = 1'b1;
                    state_d = sc_rise ? TRACK : DONE;
                end else if (sc_rise) begin
                    state_d = TRACK;
                end
            end
            DONE: begin
                state_d = bus.sample_clk ? TRACK : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sc_q      <= 1'b0;
            rc_q      <= 1'b0;
            eoc_q     <= 1'b0;
            vhold_q   <= '0;
            result_q  <= '0;
            rv_q      <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
            bit_cnt_q <= '0;
            cmp_q     <= '0;
        end else begin
            state_q   <= state_d;
            sc_q      <= bus.sample_clk;
            rc_q      <= bus.reg_clk;
            eoc_q     <= bus.EOC;
            vhold_q   <= vhold_d;
            result_q  <= result_d;
            rv_q      <= rv_d;
            err_q     <= err_d;
            count_q   <= count_d;
            bit_cnt_q <= bit_cnt_d;
            cmp_q[0]  <= raw;
            for (int unsigned i = 1; i < CMP_LAT; i++) begin
                cmp_q[i] <= cmp_q[i-1];
            end
        end
    end

    assign bus.comparator_out = cmp_q[CMP_LAT-1];
    assign bus.vhold          = vhold_q;
    assign bus.result         = result_q;
    assign bus.result_valid   = rv_q;
    assign bus.conv_err       = err_q;
    assign bus.conv_count     = count_q;
endmodule

// File: tb/tb_sar_afe_model.sv
// Closed-loop bench: a behavioural SAR controller drives three model instances
// (default, OFFSET=2, CMP_LAT=3) and checks results against hand-computed codes.
module tb_sar_afe_model;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] vin_s, d_s;
    logic       sc_s, rc_s, eoc_s;

    int n_tests = 0;
    int n_fail  = 0;

    sar_afe_if #(.N(8)) bus0 ();
    sar_afe_if #(.N(8)) bus1 ();
    sar_afe_if #(.N(8)) bus2 ();

    assign bus0.vin = vin_s;  assign bus0.sample_clk = sc_s;  assign bus0.D = d_s;
    assign bus0.reg_clk = rc_s;  assign bus0.EOC = eoc_s;
    assign bus1.vin = vin_s;  assign bus1.sample_clk = sc_s;  assign bus1.D = d_s;
    assign bus1.reg_clk = rc_s;  assign bus1.EOC = eoc_s;
    assign bus2.vin = vin_s;  assign bus2.sample_clk = sc_s;  assign bus2.D = d_s;
    assign bus2.reg_clk = rc_s;  assign bus2.EOC = eoc_s;

    sar_afe_model #(.N(8), .CMP_LAT(1), .OFFSET(0), .TOL(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sar_afe_model #(.N(8), .CMP_LAT(1), .OFFSET(2), .TOL(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sar_afe_model #(.N(8), .CMP_LAT(3), .OFFSET(0), .TOL(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vin;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_cmp(input int sel);
        case (sel)
            0:       return bus0.comparator_out;
            1:       return bus1.comparator_out;
            default: return bus2.comparator_out;
        endcase
    endfunction

    function automatic logic [7:0] get_res(input int sel);
        case (sel)
            0:       return bus0.result;
            1:       return bus1.result;
            default: return bus2.result;
        endcase
    endfunction

    function automatic logic get_rv(input int sel);
        case (sel)
            0:       return bus0.result_valid;
            1:       return bus1.result_valid;
            default: return bus2.result_valid;
        endcase
    endfunction

    function automatic logic get_err(input int sel);
        case (sel)
            0:       return bus0.conv_err;
            1:       return bus1.conv_err;
            default: return bus2.conv_err;
        endcase
    endfunction

    // Track for three cycles, then drop sample_clk; the hold happens on the next edge.
    task automatic hold_sample(input logic [7:0] v);
        vin_s = v;
        sc_s  = 1'b1;
        repeat (3) tick();
        sc_s = 1'b0;
        tick();
    endtask

    // Behavioural sar_logic: binary search on comparator_out, one reg_clk pulse per bit
    // (the last pulse skipped when npulses == 7), then EOC with either the found or a forced code.
    task automatic run_sar(input int sel, input int lat, input int npulses,
                           input bit forced, input logic [7:0] fd,
                           output logic [7:0] res, output bit rv_ok);
        logic [7:0] code;
        logic [7:0] trial;
        code = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            trial = code | (8'h01 << i);
            d_s   = trial;
            repeat (lat + 1) tick();
            if (get_cmp(sel)) code = trial;
            if (i >= 8 - npulses) begin
                rc_s = 1'b1;
                tick();
                rc_s = 1'b0;
                tick();
            end
        end
        d_s = forced ? fd : code;
        tick();
        rv_ok = (get_rv(sel) == 1'b0);
        eoc_s = 1'b1;
        tick();
        rv_ok = rv_ok && (get_rv(sel) == 1'b1);
        res   = get_res(sel);
        eoc_s = 1'b0;
        tick();
        rv_ok = rv_ok && (get_rv(sel) == 1'b0);
        tick();
        rv_ok = rv_ok && (get_rv(sel) == 1'b0);
    endtask

    initial begin
        logic [7:0] res;
        bit         rv_ok;
        int         exp_cnt;

        vecs[0] = '{8'h5A, 8'h5A};
        vecs[1] = '{8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'hFF};
        vecs[3] = '{8'h80, 8'h80};
        vecs[4] = '{8'h01, 8'h01};
        vecs[5] = '{8'h7F, 8'h7F};

        // Reset with random inputs on the bus
        rst   = 1'b1;
        vin_s = 8'($urandom);
        d_s   = 8'($urandom);
        sc_s  = 1'($urandom);
        rc_s  = 1'($urandom);
        eoc_s = 1'($urandom);
        tick();
        check("rst_cmp1", {31'd0, bus0.comparator_out}, 32'd0);
        vin_s = 8'h00; d_s = 8'h00; sc_s = 1'b0; rc_s = 1'b0; eoc_s = 1'b0;
        tick();
        check("rst_state", {30'd0, dut0.state_q}, 32'd0);
        check("rst_vhold", {24'd0, bus0.vhold}, 32'd0);
        check("rst_result", {24'd0, bus0.result}, 32'd0);
        check("rst_rv", {31'd0, bus0.result_valid}, 32'd0);
        check("rst_err", {31'd0, bus0.conv_err}, 32'd0);
        check("rst_count", {16'd0, bus0.conv_count}, 32'd0);
        check("rst_cmp2", {31'd0, bus0.comparator_out}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_cmp", {31'd0, bus0.comparator_out}, 32'd0);

        // Table of closed-loop conversions on the default instance
        exp_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            hold_sample(vecs[k].vin);
            run_sar(0, 1, 8, 1'b0, 8'h00, res, rv_ok);
            exp_cnt++;
            check($sformatf("vec%0d_result", k), {24'd0, res}, {24'd0, vecs[k].exp_res});
            check($sformatf("vec%0d_rv_pulse", k), {31'd0, rv_ok}, 32'd1);
            check($sformatf("vec%0d_count", k), {16'd0, bus0.conv_count}, exp_cnt);
            check($sformatf("vec%0d_err", k), {31'd0, bus0.conv_err}, 32'd0);
        end

        // vin changes right after the hold; conversion must use the held code
        hold_sample(8'h5A);
        vin_s = 8'hFF;
        tick();
        check("frozen_vhold", {24'd0, bus0.vhold}, 32'h5A);
        run_sar(0, 1, 8, 1'b0, 8'h00, res, rv_ok);
        exp_cnt++;
        check("frozen_result", {24'd0, res}, 32'h5A);
        check("frozen_err", {31'd0, bus0.conv_err}, 32'd0);

        // Abort after 3 reg_clk pulses
        hold_sample(8'h33);
        d_s = 8'h80;
        repeat (3) begin
            rc_s = 1'b1; tick();
            rc_s = 1'b0; tick();
        end
        sc_s = 1'b1;
        tick();
        check("abort_state", {30'd0, dut0.state_q}, 32'd1);
        check("abort_rv", {31'd0, bus0.result_valid}, 32'd0);
        tick();
        check("abort_count", {16'd0, bus0.conv_count}, exp_cnt);
        hold_sample(8'h33);
        run_sar(0, 1, 8, 1'b0, 8'h00, res, rv_ok);
        exp_cnt++;
        check("post_abort_result", {24'd0, res}, 32'h33);
        check("post_abort_count", {16'd0, bus0.conv_count}, exp_cnt);
        check("post_abort_err", {31'd0, bus0.conv_err}, 32'd0);

        // Reset mid-conversion discards it
        hold_sample(8'h44);
        rc_s = 1'b1; tick(); rc_s = 1'b0; tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_count", {16'd0, bus0.conv_count}, 32'd0);
        check("midrst_rv", {31'd0, bus0.result_valid}, 32'd0);
        check("midrst_state", {30'd0, dut0.state_q}, 32'd0);
        tick();

        // OFFSET = 2 instance
        hold_sample(8'h01);
        run_sar(1, 1, 8, 1'b0, 8'h00, res, rv_ok);
        check("off_clamp_result", {24'd0, res}, 32'h00);
        check("off_clamp_err", {31'd0, bus1.conv_err}, 32'd0);
        hold_sample(8'h01);
        run_sar(1, 1, 8, 1'b1, 8'h03, res, rv_ok);
        check("off_bad_result", {24'd0, res}, 32'h03);
        check("off_bad_err", {31'd0, bus1.conv_err}, 32'd1);
        hold_sample(8'h40);
        run_sar(1, 1, 8, 1'b0, 8'h00, res, rv_ok);
        check("off_shift_result", {24'd0, res}, 32'h3E);
        check("off_sticky_err", {31'd0, bus1.conv_err}, 32'd1);

        // CMP_LAT = 3 instance
        rst = 1'b1; tick(); rst = 1'b0; tick();
        hold_sample(8'h5A);
        run_sar(2, 3, 8, 1'b0, 8'h00, res, rv_ok);
        check("lat3_result", {24'd0, res}, 32'h5A);
        check("lat3_rv_pulse", {31'd0, rv_ok}, 32'd1);
        check("lat3_err", {31'd0, bus2.conv_err}, 32'd0);

        hold_sample(8'h40);
        d_s = 8'hFF;
        repeat (5) tick();
        check("lat3_low", {31'd0, bus2.comparator_out}, 32'd0);
        d_s = 8'h00;
        tick();
        check("lat3_step_1", {31'd0, bus2.comparator_out}, 32'd0);
        tick();
        check("lat3_step_2", {31'd0, bus2.comparator_out}, 32'd0);
        tick();
        check("lat3_step_3", {31'd0, bus2.comparator_out}, 32'd1);
        sc_s = 1'b1;
        repeat (4) tick();
        check("lat3_flush", {31'd0, bus2.comparator_out}, 32'd0);

        // Seven bit decisions with a correct final code still flag an error
        hold_sample(8'h5A);
        run_sar(2, 3, 7, 1'b0, 8'h00, res, rv_ok);
        check("short_result", {24'd0, res}, 32'h5A);
        check("short_err", {31'd0, bus2.conv_err}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
